// File: rtl/player_reg_writer_pkg.sv
// Shared constants and types for the player/CPU regfile write merger.
package player_reg_writer_pkg;
  localparam int NPLAY  = 4;
  localparam int REG_W  = 5;
  localparam int DATA_W = 32;
  localparam int ID_W   = 3;

  localparam logic [REG_W-1:0] REG_ZERO   = 5'd0;
  localparam logic [ID_W-1:0]  GRANT_CPU  = 3'd4;
  localparam logic [ID_W-1:0]  GRANT_IDLE = 3'd7;

  typedef enum logic [1:0] {
    SEL_IDLE,
    SEL_PLAYER,
    SEL_CPU,
    SEL_CPU_ZERO
  } sel_t;
endpackage

// File: rtl/rr_arbiter4.sv
// Combinational four-way round-robin arbiter.
// The search begins one past the last granted player.
module rr_arbiter4
  import player_reg_writer_pkg::*;
(
  input  logic [NPLAY-1:0] req,
  input  logic [1:0]       ptr,
  output logic [NPLAY-1:0] gnt,
  output logic [1:0]       gnt_id,
  output logic             gnt_valid
);
  logic [1:0] idx;

  always_comb begin
    gnt       = '0;
    gnt_id    = ptr;
    gnt_valid = 1'b0;
    idx       = ptr;
    for (int i = 1; i <= NPLAY; i++) begin
      idx = ptr + 2'(i);
      if (!gnt_valid && req[idx]) begin
        gnt_valid = 1'b1;
        gnt_id    = idx;
        gnt[idx]  = 1'b1;
      end
    end
  end
endmodule

// File: rtl/player_reg_writer.sv
// Merges CPU writeback and four player slots onto one regfile write port.
// CPU has priority until a pending player has waited STARVE_LIMIT cycles.
module player_reg_writer
  import player_reg_writer_pkg::*;
#(
  parameter int STARVE_LIMIT = 8,
  parameter int DROPW        = 8
) (
  input  logic                    clock,
  input  logic                    ctrl_reset,
  input  logic                    cpu_writeEnable,
  input  logic [REG_W-1:0]        cpu_writeReg,
  input  logic [DATA_W-1:0]       cpu_data,
  output logic                    cpu_stall,
  input  logic [NPLAY-1:0]        req_valid,
  input  logic [NPLAY*REG_W-1:0]  req_reg,
  input  logic [NPLAY*DATA_W-1:0] req_data,
  output logic [NPLAY-1:0]        req_ready,
  output logic                    ctrl_writeEnable,
  output logic [REG_W-1:0]        ctrl_writeReg,
  output logic [DATA_W-1:0]       data_writeReg,
  output logic [ID_W-1:0]         grant_id,
  output logic [DROPW-1:0]        drop_count
);
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  logic [NPLAY-1:0]  slot_vld;
  logic [REG_W-1:0]  slot_reg  [NPLAY];
  logic [DATA_W-1:0] slot_data [NPLAY];
  logic [1:0]        rr_ptr;
  logic [SW-1:0]     starve_cnt;

  logic [NPLAY-1:0]  arb_gnt;
  logic [1:0]        arb_id;
  logic              arb_vld;
  logic              starve_hit;
  sel_t              sel;

  logic [NPLAY-1:0]  acc;
  logic [NPLAY-1:0]  drop;
  logic [NPLAY-1:0]  clr;
  logic [2:0]        n_drop;
  logic [DROPW:0]    drop_sum;

  rr_arbiter4 u_arb (
    .req       (slot_vld),
    .ptr       (rr_ptr),
    .gnt       (arb_gnt),
    .gnt_id    (arb_id),
    .gnt_valid (arb_vld)
  );

  assign req_ready = ~slot_vld;
  assign cpu_stall = starve_hit;

  always_comb begin
    starve_hit = arb_vld &&
                 (starve_cnt == SW'(STARVE_LIMIT));
    sel = SEL_IDLE;
    if (starve_hit)
      sel = SEL_PLAYER;
    else if (cpu_writeEnable)
      sel = (cpu_writeReg != REG_ZERO) ?
            SEL_CPU : SEL_CPU_ZERO;
    else if (arb_vld)
      sel = SEL_PLAYER;
  end

  always_comb begin
    acc    = req_valid & ~slot_vld;
    drop   = '0;
    n_drop = '0;
    for (int p = 0; p < NPLAY; p++) begin
      drop[p] = acc[p] &&
        (req_reg[p*REG_W +: REG_W] == REG_ZERO);
      n_drop  = n_drop + 3'(drop[p]);
    end
    clr      = (sel == SEL_PLAYER) ? arb_gnt : '0;
    drop_sum = {1'b0, drop_count} + (DROPW+1)'(n_drop);
  end

  always_ff @(posedge clock or posedge ctrl_reset) begin
    if (ctrl_reset) begin
      slot_vld <= '0;
      for (int p = 0; p < NPLAY; p++) begin
        slot_reg[p]  <= '0;
        slot_data[p] <= '0;
      end
    end else begin
      for (int p = 0; p < NPLAY; p++) begin
        if (clr[p]) begin
          slot_vld[p] <= 1'b0;
        end else if (acc[p] && !drop[p]) begin
          slot_vld[p]  <= 1'b1;
          slot_reg[p]  <= req_reg[p*REG_W +: REG_W];
          slot_data[p] <= req_data[p*DATA_W +: DATA_W];
        end
      end
    end
  end

  always_ff @(posedge clock or posedge ctrl_reset) begin
    if (ctrl_reset)
      drop_count <= '0;
    else if (drop_sum[DROPW])
      drop_count <= '1;
    else
      drop_count <= drop_sum[DROPW-1:0];
  end

  // A CPU write to r0 still counts as a CPU win.
  always_ff @(posedge clock or posedge ctrl_reset) begin
    if (ctrl_reset)
      starve_cnt <= '0;
    else if (sel == SEL_PLAYER || !arb_vld)
      starve_cnt <= '0;
    else
      starve_cnt <= starve_cnt + 1'b1;
  end

  always_ff @(posedge clock or posedge ctrl_reset) begin
    if (ctrl_reset) begin
      ctrl_writeEnable <= 1'b0;
      ctrl_writeReg    <= '0;
      data_writeReg    <= '0;
      grant_id         <= GRANT_IDLE;
      rr_ptr           <= 2'd3;
    end else begin
      unique case (sel)
        SEL_PLAYER: begin
          ctrl_writeEnable <= 1'b1;
          ctrl_writeReg    <= slot_reg[arb_id];
          data_writeReg    <= slot_data[arb_id];
          grant_id         <= {1'b0, arb_id};
          rr_ptr           <= arb_id;
        end
        SEL_CPU: begin
          ctrl_writeEnable <= 1'b1;
          ctrl_writeReg    <= cpu_writeReg;
          data_writeReg    <= cpu_data;
          grant_id         <= GRANT_CPU;
        end
        default: begin
          ctrl_writeEnable <= 1'b0;
          grant_id         <= GRANT_IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_player_reg_writer.sv
// Directed self-checking bench for player_reg_writer.
module tb_player_reg_writer;
  logic         clock = 1'b0;
  logic         ctrl_reset;
  logic         cpu_writeEnable;
  logic [4:0]   cpu_writeReg;
  logic [31:0]  cpu_data;
  logic         cpu_stall;
  logic [3:0]   req_valid;
  logic [19:0]  req_reg;
  logic [127:0] req_data;
  logic [3:0]   req_ready;
  logic         ctrl_writeEnable;
  logic [4:0]   ctrl_writeReg;
  logic [31:0]  data_writeReg;
  logic [2:0]   grant_id;
  logic [7:0]   drop_count;

  int n_vec = 0;
  int n_err = 0;

  player_reg_writer dut (
    .clock            (clock),
    .ctrl_reset       (ctrl_reset),
    .cpu_writeEnable  (cpu_writeEnable),
    .cpu_writeReg     (cpu_writeReg),
    .cpu_data         (cpu_data),
    .cpu_stall        (cpu_stall),
    .req_valid        (req_valid),
    .req_reg          (req_reg),
    .req_data         (req_data),
    .req_ready        (req_ready),
    .ctrl_writeEnable (ctrl_writeEnable),
    .ctrl_writeReg    (ctrl_writeReg),
    .data_writeReg    (data_writeReg),
    .grant_id         (grant_id),
    .drop_count       (drop_count)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic set_req(input int p,
                         input logic [4:0] r,
                         input logic [31:0] d);
    req_valid[p]        = 1'b1;
    req_reg[5*p +: 5]   = r;
    req_data[32*p +: 32] = d;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: got hang expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    ctrl_reset      = 1'b1;
    cpu_writeEnable = 1'b0;
    cpu_writeReg    = '0;
    cpu_data        = '0;
    req_valid       = '0;
    req_reg         = '0;
    req_data        = '0;
    step();
    step();
    ctrl_reset = 1'b0;
    check("rst_we",    32'(ctrl_writeEnable), 32'd0);
    check("rst_reg",   32'(ctrl_writeReg),    32'd0);
    check("rst_data",  data_writeReg,         32'd0);
    check("rst_gid",   32'(grant_id),         32'd7);
    check("rst_ready", 32'(req_ready),        32'hF);
    check("rst_drop",  32'(drop_count),       32'd0);
    check("rst_stall", 32'(cpu_stall),        32'd0);

    // P1 single write
    set_req(1, 5'd2, 32'hDEAD_BEEF);
    step();
    req_valid = '0;
    check("p1_ready_lo", 32'(req_ready), 32'hD);
    check("p1_we_lat",   32'(ctrl_writeEnable), 32'd0);
    step();
    check("p1_we",    32'(ctrl_writeEnable), 32'd1);
    check("p1_reg",   32'(ctrl_writeReg),    32'd2);
    check("p1_data",  data_writeReg,         32'hDEAD_BEEF);
    check("p1_gid",   32'(grant_id),         32'd1);
    check("p1_ready", 32'(req_ready),        32'hF);
    step();
    check("idle_we",   32'(ctrl_writeEnable), 32'd0);
    check("idle_gid",  32'(grant_id),         32'd7);
    check("idle_reg",  32'(ctrl_writeReg),    32'd2);
    check("idle_data", data_writeReg,         32'hDEAD_BEEF);

    // Reset mid-stream with P1 pending
    set_req(1, 5'd5, 32'h0000_1234);
    step();
    req_valid = '0;
    check("mid_ready_lo", 32'(req_ready), 32'hD);
    #2 ctrl_reset = 1'b1;
    #1;
    check("mid_ready", 32'(req_ready),        32'hF);
    check("mid_we",    32'(ctrl_writeEnable), 32'd0);
    check("mid_gid",   32'(grant_id),         32'd7);
    check("mid_reg",   32'(ctrl_writeReg),    32'd0);
    check("mid_data",  data_writeReg,         32'd0);
    step();
    ctrl_reset = 1'b0;
    step();
    check("mid_lost_we", 32'(ctrl_writeEnable), 32'd0);

    // All four players at once
    for (int p = 0; p < 4; p++)
      set_req(p, 5'(10 + p), 32'hA0 + 32'(p));
    step();
    req_valid = '0;
    for (int p = 0; p < 4; p++) begin
      step();
      check("rr_gid",  32'(grant_id),      32'(p));
      check("rr_reg",  32'(ctrl_writeReg), 32'(10 + p));
      check("rr_data", data_writeReg,      32'hA0 + 32'(p));
      if (p == 0)
        check("rr_ready0", 32'(req_ready), 32'h1);
    end
    step();
    check("rr_done", 32'(grant_id), 32'd7);

    // CPU streams r7, P2 starves then preempts
    set_req(2, 5'd20, 32'h2222_2222);
    cpu_writeEnable = 1'b1;
    cpu_writeReg    = 5'd7;
    cpu_data        = 32'h0000_0777;
    step();
    req_valid = '0;
    check("st_first_gid", 32'(grant_id), 32'd4);
    for (int i = 1; i <= 8; i++) begin
      check("st_stall_lo", 32'(cpu_stall), 32'd0);
      step();
      check("st_cpu_gid", 32'(grant_id),      32'd4);
      check("st_cpu_reg", 32'(ctrl_writeReg), 32'd7);
    end
    check("st_stall_hi", 32'(cpu_stall), 32'd1);
    step();
    check("st_p2_gid",  32'(grant_id),      32'd2);
    check("st_p2_reg",  32'(ctrl_writeReg), 32'd20);
    check("st_p2_data", data_writeReg,      32'h2222_2222);
    check("st_stall_clr", 32'(cpu_stall),   32'd0);
    step();
    check("st_held_gid",  32'(grant_id),      32'd4);
    check("st_held_reg",  32'(ctrl_writeReg), 32'd7);
    check("st_held_data", data_writeReg,      32'h0000_0777);
    cpu_writeEnable = 1'b0;
    step();

    // P0 writes to r0 are dropped
    set_req(0, 5'd0, 32'h5555_5555);
    for (int i = 0; i < 3; i++) begin
      step();
      check("dr_we",    32'(ctrl_writeEnable), 32'd0);
      check("dr_ready", 32'(req_ready),        32'hF);
    end
    req_valid = '0;
    check("dr_count", 32'(drop_count), 32'd3);
    cpu_writeEnable = 1'b1;
    cpu_writeReg    = 5'd0;
    cpu_data        = 32'hFFFF_FFFF;
    step();
    cpu_writeEnable = 1'b0;
    check("cpu0_we",   32'(ctrl_writeEnable), 32'd0);
    check("cpu0_gid",  32'(grant_id),         32'd7);
    check("cpu0_drop", 32'(drop_count),       32'd3);

    // Saturation of the drop counter
    set_req(0, 5'd0, 32'h0);
    for (int i = 0; i < 260; i++)
      step();
    req_valid = '0;
    check("dr_sat", 32'(drop_count), 32'hFF);

    // P3 and CPU together: CPU first
    set_req(3, 5'd4, 32'h3333_3333);
    cpu_writeEnable = 1'b1;
    cpu_writeReg    = 5'd9;
    cpu_data        = 32'h9999_9999;
    step();
    req_valid       = '0;
    cpu_writeEnable = 1'b0;
    check("co_cpu_gid", 32'(grant_id),      32'd4);
    check("co_cpu_reg", 32'(ctrl_writeReg), 32'd9);
    step();
    check("co_p3_gid",  32'(grant_id),      32'd3);
    check("co_p3_reg",  32'(ctrl_writeReg), 32'd4);
    check("co_p3_data", data_writeReg,      32'h3333_3333);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end
endmodule
